// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the framed link (tx framer and rx checker).
// Poly 0x07, MSB-first, no reflection, no final XOR.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY   = 8'h07;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DROP,
        ST_SOF,
        ST_LEN,
        ST_DATA,
        ST_CRC
    } state_t;

    // One byte folded into the CRC register, most significant bit first.
    function automatic logic [7:0] crc8_next(
        input logic [7:0] crc,
        input logic [7:0] d
    );
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ d[i])
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            else
                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_frame_tx.sv
// Byte-stream framer: buffers one payload, then emits SOF, LEN, payload, CRC-8.
// Ports: clk, reset_n (async, active-low); s_data/s_valid/s_last/s_ready upstream
// stream; m_data/m_valid/m_last/m_ready framed output; busy; err_overlen pulse.
module crc8_frame_tx
    import crc8_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       err_overlen
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_LEN - 1);
    localparam logic [PW-1:0] FULL_LEN = PW'(MAX_LEN);

    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_len;
    logic [7:0]    r_crc;
    logic          r_alive;
    logic          r_err;
    logic [7:0]    r_buf [MAX_LEN];

    logic          w_fill;
    logic          w_recv;
    logic          w_s_hs;
    logic          w_m_hs;
    logic [7:0]    w_m_data;
    logic [7:0]    w_len8;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_fill   = (r_state == ST_FILL);
    assign w_recv   = w_fill || (r_state == ST_DROP);
    assign w_len8   = 8'(r_len);
    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // r_alive keeps s_ready low for the first cycle after reset release.
    assign s_ready     = r_alive && w_recv;
    assign m_valid     = !w_recv;
    assign m_last      = (r_state == ST_CRC);
    assign m_data      = w_m_data;
    assign busy        = !(w_fill && (r_wr_ptr == '0));
    assign err_overlen = r_err;

    assign w_s_hs = s_valid && s_ready;
    assign w_m_hs = m_valid && m_ready;

    always_comb begin
        w_m_data = 8'h00;
        unique case (r_state)
            ST_SOF:  w_m_data = SOF_BYTE;
            ST_LEN:  w_m_data = w_len8;
            ST_DATA: w_m_data = r_buf[w_rd_idx];
            ST_CRC:  w_m_data = r_crc;
            default: w_m_data = 8'h00;
        endcase
    end

    // Payload storage carries no reset: contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_fill && w_s_hs)
            r_buf[w_wr_idx] <= s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_FILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_len    <= '0;
            r_crc    <= CRC_INIT;
            r_alive  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_err   <= 1'b0;
            unique case (r_state)
                ST_FILL: begin
                    if (w_s_hs) begin
                        if (s_last) begin
                            r_len    <= r_wr_ptr + 1'b1;
                            r_crc    <= CRC_INIT;
                            r_rd_ptr <= '0;
                            r_state  <= ST_SOF;
                        end else if (r_wr_ptr == LAST_IDX) begin
                            // Buffer full with more to come: keep it, drop the rest.
                            r_len   <= FULL_LEN;
                            r_err   <= 1'b1;
                            r_state <= ST_DROP;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_s_hs && s_last) begin
                        r_crc    <= CRC_INIT;
                        r_rd_ptr <= '0;
                        r_state  <= ST_SOF;
                    end
                end
                ST_SOF: begin
                    if (w_m_hs)
                        r_state <= ST_LEN;
                end
                ST_LEN: begin
                    if (w_m_hs) begin
                        r_crc   <= crc8_next(r_crc, w_len8);
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_m_hs) begin
                        r_crc    <= crc8_next(r_crc, w_m_data);
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        if (r_rd_ptr == r_len - 1'b1)
                            r_state <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (w_m_hs) begin
                        r_wr_ptr <= '0;
                        r_state  <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Self-checking bench for crc8_frame_tx: vector table, random frames,
// back-to-back, overlength and mid-frame reset against a long-division CRC model.
module tb_crc8_frame_tx;
    import crc8_pkg::*;

    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       busy;
    logic       err_overlen;

    crc8_frame_tx #(
        .SOF_BYTE(8'hA5),
        .MAX_LEN (MAX_LEN),
        .CRC_INIT(8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .err_overlen(err_overlen)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int  cyc = 0;
    int  last_hs_cyc = 0;
    int  sof_cyc = 0;
    int  last_cyc = 0;
    int  stab_err = 0;
    int  inv_err = 0;
    int  err_cnt = 0;
    bit  chk_en = 1'b0;
    bit  rnd_rdy = 1'b0;

    logic       p_vld = 1'b0;
    logic       p_rdy = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       p_last = 1'b0;

    logic [7:0] got_q[$];
    bit         got_last_q[$];
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];

    typedef struct {
        int         n;
        logic [7:0] d [24];
        bit         rnd;
        int         exp_len;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1.
    function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
        bit         bits[$];
        logic [8:0] r;
        foreach (msg[k])
            for (int b = 7; b >= 0; b--)
                bits.push_back(msg[k][b]);
        for (int b = 0; b < 8; b++)
            bits.push_back(1'b0);
        r = 9'h000;
        foreach (bits[k]) begin
            r = {r[7:0], bits[k]};
            if (r[8])
                r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic push_expected(input logic [7:0] pl[$]);
        logic [7:0] msg[$];
        int         n;
        n = (pl.size() > MAX_LEN) ? MAX_LEN : pl.size();
        msg.push_back(8'(n));
        for (int k = 0; k < n; k++)
            msg.push_back(pl[k]);
        exp_q.push_back(8'hA5);
        exp_last_q.push_back(1'b0);
        foreach (msg[k]) begin
            exp_q.push_back(msg[k]);
            exp_last_q.push_back(1'b0);
        end
        exp_q.push_back(model_crc(msg));
        exp_last_q.push_back(1'b1);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            p_vld = 1'b0;
            p_rdy = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
                if (m_last)
                    last_cyc = cyc;
            end
            if (m_valid && !p_vld)
                sof_cyc = cyc;
            if (p_vld && !p_rdy)
                if (!(m_valid && m_data === p_data && m_last === p_last))
                    stab_err++;
            if (chk_en && (s_ready !== !m_valid))
                inv_err++;
            if (err_overlen)
                err_cnt++;
            p_vld  = m_valid;
            p_rdy  = m_ready;
            p_data = m_data;
            p_last = m_last;
        end
    end

    task automatic send(input logic [7:0] pl[$], input bit gaps);
        int i;
        int to;
        i  = 0;
        to = 0;
        while (i < pl.size() && to < 3000) begin
            @(posedge clk);
            #1;
            to++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = pl[i];
                s_last  = (i == pl.size() - 1);
                if (s_ready) begin
                    if (s_last)
                        last_hs_cyc = cyc;
                    i++;
                end
            end
        end
        if (to >= 3000)
            check("send_timeout", 32'(i), 32'(pl.size()));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("wait_output", 32'(got_q.size() >= exp_q.size()), 32'd1);
    endtask

    task automatic compare_streams(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i),
                  {23'd0, got_last_q[i], got_q[i]},
                  {23'd0, exp_last_q[i], exp_q[i]});
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] c;
        string      s;
        int         e0;

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b1;
        #1;
        check("reset_outputs",
              {20'd0, m_data, m_valid, m_last, s_ready, busy, err_overlen},
              32'd0);

        s = "123456789";
        c = 8'h00;
        for (int i = 0; i < 9; i++)
            c = crc8_next(c, s[i]);
        check("pkg_crc_123456789", 32'(c), 32'hF4);

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("s_ready_low_after_release", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        check("s_ready_rises", 32'(s_ready), 32'd1);
        chk_en = 1'b1;

        vecs[0].n = 1; vecs[0].d[0] = 8'h01;
        vecs[0].rnd = 1'b0; vecs[0].exp_len = 1; vecs[0].exp_err = 0;
        vecs[1].n = 3;
        vecs[1].d[0] = 8'h00; vecs[1].d[1] = 8'hFF; vecs[1].d[2] = 8'h55;
        vecs[1].rnd = 1'b1; vecs[1].exp_len = 3; vecs[1].exp_err = 0;
        vecs[2].n = MAX_LEN + 3; vecs[2].rnd = 1'b1;
        vecs[2].exp_len = MAX_LEN; vecs[2].exp_err = 1;
        vecs[3].n = MAX_LEN; vecs[3].rnd = 1'b0;
        vecs[3].exp_len = MAX_LEN; vecs[3].exp_err = 0;
        vecs[4].n = MAX_LEN + 1; vecs[4].rnd = 1'b0;
        vecs[4].exp_len = MAX_LEN; vecs[4].exp_err = 1;
        for (int v = 2; v < 5; v++)
            for (int k = 0; k < vecs[v].n; k++)
                vecs[v].d[k] = 8'(k * 7 + v);

        for (int v = 0; v < 5; v++) begin
            pl.delete();
            for (int k = 0; k < vecs[v].n; k++)
                pl.push_back(vecs[v].d[k]);
            rnd_rdy = vecs[v].rnd;
            e0 = err_cnt;
            push_expected(pl);
            send(pl, 1'b0);
            idle();
            wait_out();
            if (got_q.size() > 1)
                check($sformatf("v%0d_len", v), 32'(got_q[1]),
                      32'(vecs[v].exp_len));
            check($sformatf("v%0d_err_pulses", v), 32'(err_cnt - e0),
                  32'(vecs[v].exp_err));
            if (v == 0) begin
                if (got_q.size() == 4) begin
                    check("v0_b0", 32'(got_q[0]), 32'hA5);
                    check("v0_b1", 32'(got_q[1]), 32'h01);
                    check("v0_b2", 32'(got_q[2]), 32'h01);
                    check("v0_b3", 32'(got_q[3]), 32'h12);
                end
                check("v0_sof_latency", 32'(sof_cyc - last_hs_cyc), 32'd1);
                check("v0_throughput", 32'(last_cyc - sof_cyc), 32'd3);
                check("v0_busy_idle", 32'(busy), 32'd0);
            end
            compare_streams($sformatf("v%0d", v));
        end
        check("stable_under_backpressure", 32'(stab_err), 32'd0);

        rnd_rdy = 1'b0;
        for (int f = 0; f < 4; f++) begin
            pl.delete();
            for (int k = 0; k < int'($urandom_range(1, 8)); k++)
                pl.push_back(8'($urandom));
            push_expected(pl);
            send(pl, 1'b0);
        end
        idle();
        wait_out();
        compare_streams("b2b");
        check("b2b_ready_span", 32'(inv_err), 32'd0);

        rnd_rdy = 1'b1;
        e0 = err_cnt;
        for (int f = 0; f < 20; f++) begin
            pl.delete();
            for (int k = 0; k < int'($urandom_range(1, MAX_LEN + 4)); k++)
                pl.push_back(8'($urandom));
            push_expected(pl);
            send(pl, 1'b1);
            idle();
        end
        wait_out();
        compare_streams("rand");
        check("rand_stable", 32'(stab_err), 32'd0);
        check("rand_ready_span", 32'(inv_err), 32'd0);

        rnd_rdy = 1'b0;
        pl.delete();
        for (int k = 0; k < 8; k++)
            pl.push_back(8'(8'h30 + k));
        send(pl, 1'b0);
        idle();
        begin
            int t;
            t = 0;
            while (got_q.size() < 4 && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            check("rst_reach_data", 32'(got_q.size() >= 4), 32'd1);
        end
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {20'd0, m_data, m_valid, m_last, s_ready, busy, err_overlen},
              32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_q.delete();
        got_last_q.delete();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        pl.delete();
        pl.push_back(8'h7E);
        push_expected(pl);
        send(pl, 1'b0);
        idle();
        wait_out();
        compare_streams("after_rst");
        check("final_ready_span", 32'(inv_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
